systolic_pe_acc: RTL and testbench

Parametrised next-generation processing element for the systolic matrix-multiply array. Each PE multiplies the operands arriving from above and from the left, accumulates the products for the current output tile, and forwards both operands with their valid/last tags to the neighbours below and to the right one cycle later. It adds several features to the basic multiply-accumulate cell:
- valid-qualified accumulation;
- tile framing via a `last` tag, with a registered result and a one-cycle result strobe;
- signed/unsigned and saturating/wrapping arithmetic;
- an optional multiplier pipeline register.

---
 rtl/systolic_pkg.sv | 59 +++++
 rtl/pe_sat_add.sv | 44 ++++
 rtl/systolic_pe_acc.sv | 156 +++++++++++++++
 tb/tb_systolic_pe_acc.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array blocks: arithmetic mode
// constants, accumulator range helpers and the width-check macro.

`ifndef SYSTOLIC_PKG_SV
`define SYSTOLIC_PKG_SV

// Elaboration-time guard; expands to a generate block that only exists
// (and errors out) when the condition does not hold.
`define SYSTOLIC_WIDTH_CHECK(COND, MSG) \
   if (!(COND)) begin : g_width_check_fail \
      $error(MSG); \
   end

package systolic_pkg;

   // Arithmetic mode selectors
   localparam bit MODE_SIGNED   = 1'b1;
   localparam bit MODE_UNSIGNED = 1'b0;
   localparam bit MODE_SAT      = 1'b1;
   localparam bit MODE_WRAP     = 1'b0;

   // Widest accumulator the helpers can describe; callers slice the result
   localparam int ACC_MAX_W = 128;

   // Largest two's-complement value of a w-bit accumulator
   function automatic logic [ACC_MAX_W-1:0] acc_max_s(input int w);
      logic [ACC_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < w - 1; i++) r[i] = 1'b1;
      return r;
   endfunction

   // Most negative two's-complement value of a w-bit accumulator
   function automatic logic [ACC_MAX_W-1:0] acc_min_s(input int w);
      logic [ACC_MAX_W-1:0] r;
      r = '0;
      r[w-1] = 1'b1;
      return r;
   endfunction

   // Largest unsigned value of a w-bit accumulator
   function automatic logic [ACC_MAX_W-1:0] acc_max_u(input int w);
      logic [ACC_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < w; i++) r[i] = 1'b1;
      return r;
   endfunction

   // Smallest unsigned value (zero) of a w-bit accumulator
   function automatic logic [ACC_MAX_W-1:0] acc_min_u(input int w);
      logic [ACC_MAX_W-1:0] r;
      r = '0;
      r[w-1] = 1'b0;
      return r;
   endfunction

endpackage

`endif

// File: rtl/pe_sat_add.sv
// Combinational accumulator adder with overflow detection and optional
// clamping to the representable accumulator range.

module pe_sat_add
   import systolic_pkg::*;
#(
   parameter int ACC_W    = 40,
   parameter bit SIGNED   = MODE_SIGNED,
   parameter bit SATURATE = MODE_SAT
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [ACC_W-1:0] ext_prod,
   output logic [ACC_W-1:0] sum,
   output logic             overflow
);

   localparam logic [ACC_MAX_W-1:0] MAX_WIDE = SIGNED ? acc_max_s(ACC_W) : acc_max_u(ACC_W);
   localparam logic [ACC_MAX_W-1:0] MIN_WIDE = SIGNED ? acc_min_s(ACC_W) : acc_min_u(ACC_W);
   localparam logic [ACC_W-1:0]     ACC_MAX  = MAX_WIDE[ACC_W-1:0];
   localparam logic [ACC_W-1:0]     ACC_MIN  = MIN_WIDE[ACC_W-1:0];

   logic             acc_top;
   logic             prod_top;
   logic [ACC_W:0]   sum_wide;

   // One extra bit: sign extension in signed mode, carry-out in unsigned mode.
   // In signed mode the top bit is the true sign of the exact sum, so a
   // disagreement with bit ACC_W-1 is the same as "equal operand signs,
   // different result sign".
   assign acc_top  = SIGNED ? acc[ACC_W-1]      : 1'b0;
   assign prod_top = SIGNED ? ext_prod[ACC_W-1] : 1'b0;
   assign sum_wide = {acc_top, acc} + {prod_top, ext_prod};
   assign overflow = SIGNED ? (sum_wide[ACC_W] ^ sum_wide[ACC_W-1]) : sum_wide[ACC_W];

   // Pick the wrapped sum or the clamp value in the direction of the overflow
   always_comb begin
      sum = sum_wide[ACC_W-1:0];
      if (SATURATE && overflow) begin
         if (SIGNED && sum_wide[ACC_W]) sum = ACC_MIN;
         else                           sum = ACC_MAX;
      end
   end

endmodule

// File: rtl/systolic_pe_acc.sv
// Systolic processing element: forwards operands down/right one cycle later,
// multiplies paired valid operands and accumulates them into a tile result
// framed by the last tag.

module systolic_pe_acc
   import systolic_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int ACC_W    = 40,
   parameter bit SIGNED   = MODE_SIGNED,
   parameter bit SATURATE = MODE_SAT,
   parameter bit MUL_REG  = 1'b0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [DATA_W-1:0] up_i,
   input  logic              up_valid_i,
   input  logic [DATA_W-1:0] left_i,
   input  logic              left_valid_i,
   input  logic              left_last_i,
   input  logic              clear_i,
   output logic [DATA_W-1:0] down_o,
   output logic              down_valid_o,
   output logic [DATA_W-1:0] right_o,
   output logic              right_valid_o,
   output logic              right_last_o,
   output logic [ACC_W-1:0]  res_o,
   output logic              res_valid_o,
   output logic              ovf_o
);

   localparam int PROD_W = 2 * DATA_W;

   `SYSTOLIC_WIDTH_CHECK(ACC_W >= PROD_W, "systolic_pe_acc: ACC_W must be at least 2*DATA_W")

   logic              fire;
   logic [ACC_W-1:0]  prod_ext;
   logic [ACC_W-1:0]  acc_prod;
   logic              acc_fire;
   logic              acc_last;
   logic [ACC_W-1:0]  acc_q;
   logic              ovf_sticky_q;
   logic [ACC_W-1:0]  sum;
   logic              overflow;

   assign fire = up_valid_i & left_valid_i;

   // Full-width product, extended to the accumulator width per signedness
   if (SIGNED) begin : g_mul_signed
      logic signed [PROD_W-1:0] a_s;
      logic signed [PROD_W-1:0] b_s;
      logic signed [PROD_W-1:0] p_s;
      assign a_s      = PROD_W'($signed(up_i));
      assign b_s      = PROD_W'($signed(left_i));
      assign p_s      = a_s * b_s;
      assign prod_ext = ACC_W'(p_s);
   end else begin : g_mul_unsigned
      logic [PROD_W-1:0] a_u;
      logic [PROD_W-1:0] b_u;
      logic [PROD_W-1:0] p_u;
      assign a_u      = PROD_W'(up_i);
      assign b_u      = PROD_W'(left_i);
      assign p_u      = a_u * b_u;
      assign prod_ext = ACC_W'(p_u);
   end

   // Optional product pipeline stage; clear drops the beat held in it
   if (MUL_REG) begin : g_mul_reg
      logic [ACC_W-1:0] prod_q;
      logic             fire_q;
      logic             last_q;

      // Register product and its fire/last qualifiers
      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            prod_q <= '0;
            fire_q <= 1'b0;
            last_q <= 1'b0;
         end else if (clear_i) begin
            prod_q <= prod_ext;
            fire_q <= 1'b0;
            last_q <= 1'b0;
         end else begin
            prod_q <= prod_ext;
            fire_q <= fire;
            last_q <= left_last_i;
         end
      end

      assign acc_prod = prod_q;
      assign acc_fire = fire_q;
      assign acc_last = last_q;
   end else begin : g_mul_comb
      assign acc_prod = prod_ext;
      assign acc_fire = fire;
      assign acc_last = left_last_i;
   end

   pe_sat_add #(
      .ACC_W    (ACC_W),
      .SIGNED   (SIGNED),
      .SATURATE (SATURATE)
   ) u_sat_add (
      .acc      (acc_q),
      .ext_prod (acc_prod),
      .sum      (sum),
      .overflow (overflow)
   );

   // Operand forwarding; data outputs only move on a valid beat
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         down_o        <= '0;
         down_valid_o  <= 1'b0;
         right_o       <= '0;
         right_valid_o <= 1'b0;
         right_last_o  <= 1'b0;
      end else begin
         down_valid_o  <= up_valid_i;
         right_valid_o <= left_valid_i;
         right_last_o  <= left_last_i;
         if (up_valid_i)   down_o  <= up_i;
         if (left_valid_i) right_o <= left_i;
      end
   end

   // Accumulate, complete tiles and publish results; clear aborts the tile
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         acc_q        <= '0;
         ovf_sticky_q <= 1'b0;
         res_o        <= '0;
         res_valid_o  <= 1'b0;
         ovf_o        <= 1'b0;
      end else if (clear_i) begin
         acc_q        <= '0;
         ovf_sticky_q <= 1'b0;
         res_valid_o  <= 1'b0;
      end else begin
         res_valid_o <= 1'b0;
         if (acc_fire) begin
            if (acc_last) begin
               res_o        <= sum;
               res_valid_o  <= 1'b1;
               ovf_o        <= ovf_sticky_q | overflow;
               acc_q        <= '0;
               ovf_sticky_q <= 1'b0;
            end else begin
               acc_q        <= sum;
               ovf_sticky_q <= ovf_sticky_q | overflow;
            end
         end
      end
   end

endmodule

// File: tb/tb_systolic_pe_acc.sv
// Directed bench for systolic_pe_acc: four configurations share one stimulus
// stream (default, MUL_REG=1, 32-bit saturating, 32-bit wrapping).

module tb_systolic_pe_acc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] up;
   logic        up_valid;
   logic [15:0] left;
   logic        left_valid;
   logic        left_last;
   logic        clear;

   int total = 0;
   int bad   = 0;

   // default instance outputs
   logic [15:0] d_down, d_right;
   logic        d_down_v, d_right_v, d_right_l, d_res_v, d_ovf;
   logic [39:0] d_res;
   // MUL_REG=1 instance outputs
   logic [15:0] m_down, m_right;
   logic        m_down_v, m_right_v, m_right_l, m_res_v, m_ovf;
   logic [39:0] m_res;
   // ACC_W=32 saturating instance outputs
   logic [15:0] s_down, s_right;
   logic        s_down_v, s_right_v, s_right_l, s_res_v, s_ovf;
   logic [31:0] s_res;
   // ACC_W=32 wrapping instance outputs
   logic [15:0] w_down, w_right;
   logic        w_down_v, w_right_v, w_right_l, w_res_v, w_ovf;
   logic [31:0] w_res;

   always #5 clk = ~clk;

   systolic_pe_acc #(.DATA_W(16), .ACC_W(40), .SIGNED(1'b1), .SATURATE(1'b1), .MUL_REG(1'b0)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .up_i(up), .up_valid_i(up_valid), .left_i(left),
      .left_valid_i(left_valid), .left_last_i(left_last), .clear_i(clear),
      .down_o(d_down), .down_valid_o(d_down_v), .right_o(d_right), .right_valid_o(d_right_v),
      .right_last_o(d_right_l), .res_o(d_res), .res_valid_o(d_res_v), .ovf_o(d_ovf));

   systolic_pe_acc #(.DATA_W(16), .ACC_W(40), .SIGNED(1'b1), .SATURATE(1'b1), .MUL_REG(1'b1)) u_mreg (
      .clk_i(clk), .rst_ni(rst_n), .up_i(up), .up_valid_i(up_valid), .left_i(left),
      .left_valid_i(left_valid), .left_last_i(left_last), .clear_i(clear),
      .down_o(m_down), .down_valid_o(m_down_v), .right_o(m_right), .right_valid_o(m_right_v),
      .right_last_o(m_right_l), .res_o(m_res), .res_valid_o(m_res_v), .ovf_o(m_ovf));

   systolic_pe_acc #(.DATA_W(16), .ACC_W(32), .SIGNED(1'b1), .SATURATE(1'b1), .MUL_REG(1'b0)) u_sat (
      .clk_i(clk), .rst_ni(rst_n), .up_i(up), .up_valid_i(up_valid), .left_i(left),
      .left_valid_i(left_valid), .left_last_i(left_last), .clear_i(clear),
      .down_o(s_down), .down_valid_o(s_down_v), .right_o(s_right), .right_valid_o(s_right_v),
      .right_last_o(s_right_l), .res_o(s_res), .res_valid_o(s_res_v), .ovf_o(s_ovf));

   systolic_pe_acc #(.DATA_W(16), .ACC_W(32), .SIGNED(1'b1), .SATURATE(1'b0), .MUL_REG(1'b0)) u_wrap (
      .clk_i(clk), .rst_ni(rst_n), .up_i(up), .up_valid_i(up_valid), .left_i(left),
      .left_valid_i(left_valid), .left_last_i(left_last), .clear_i(clear),
      .down_o(w_down), .down_valid_o(w_down_v), .right_o(w_right), .right_valid_o(w_right_v),
      .right_last_o(w_right_l), .res_o(w_res), .res_valid_o(w_res_v), .ovf_o(w_ovf));

   // advance one edge; outputs are read 1 time unit after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [15:0] u, input logic uv, input logic [15:0] l,
                       input logic lv, input logic last);
      up = u; up_valid = uv; left = l; left_valid = lv; left_last = last;
   endtask

   task automatic idle();
      beat(16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clear = 1'b0;
      beat(16'h1234, 1'b1, 16'h5678, 1'b1, 1'b1);
      step(); step();
      total++; if ({d_down, d_right} !== 32'h0) begin bad++; $display("FAIL reset_data: got %h/%h want 0/0", d_down, d_right); end
      total++; if ({d_down_v, d_right_v, d_right_l, d_res_v, d_ovf} !== 5'b0) begin bad++; $display("FAIL reset_flags: got %b want 00000", {d_down_v, d_right_v, d_right_l, d_res_v, d_ovf}); end
      total++; if (d_res !== 40'h0 || m_res !== 40'h0 || s_res !== 32'h0 || w_res !== 32'h0) begin bad++; $display("FAIL reset_res: got %h %h %h %h want 0", d_res, m_res, s_res, w_res); end
      rst_n = 1'b1; idle();
      step();
      $display("reset: res=%0d res_valid=%b", d_res, d_res_v);
   endtask

   task automatic test_basic();
      beat(16'd3, 1'b1, 16'd4, 1'b1, 1'b0);
      step();
      total++; if (d_down !== 16'd3 || d_right !== 16'd4 || m_down !== 16'd3 || m_right !== 16'd4) begin bad++; $display("FAIL fwd_beat1: got %0d/%0d mreg %0d/%0d want 3/4", d_down, d_right, m_down, m_right); end
      beat(16'hFFFE, 1'b1, 16'd5, 1'b1, 1'b0);
      step();
      total++; if (d_down !== 16'hFFFE || d_right !== 16'd5 || d_down_v !== 1'b1 || d_right_v !== 1'b1) begin bad++; $display("FAIL fwd_beat2: got %h/%h v=%b%b want fffe/0005 v=11", d_down, d_right, d_down_v, d_right_v); end
      beat(16'd7, 1'b1, 16'd1, 1'b1, 1'b1);
      step();
      total++; if (d_down !== 16'd7 || d_right !== 16'd1 || d_right_l !== 1'b1 || m_right_l !== 1'b1) begin bad++; $display("FAIL fwd_beat3: got %0d/%0d last=%b mreg_last=%b want 7/1 last=1", d_down, d_right, d_right_l, m_right_l); end
      total++; if (d_res_v !== 1'b1 || d_res !== 40'd9 || d_ovf !== 1'b0) begin bad++; $display("FAIL basic_res: got v=%b res=%0d ovf=%b want v=1 res=9 ovf=0", d_res_v, d_res, d_ovf); end
      total++; if (m_res_v !== 1'b0) begin bad++; $display("FAIL mreg_early: got res_valid=%b want 0", m_res_v); end
      total++; if (s_res !== 32'd9 || w_res !== 32'd9 || s_res_v !== 1'b1) begin bad++; $display("FAIL acc32_res: got %0d/%0d v=%b want 9/9 v=1", s_res, w_res, s_res_v); end
      $display("basic: res=%0d res_valid=%b ovf=%b", d_res, d_res_v, d_ovf);
      idle();
      step();
      total++; if (d_res_v !== 1'b0 || d_res !== 40'd9) begin bad++; $display("FAIL basic_strobe_len: got v=%b res=%0d want v=0 res=9", d_res_v, d_res); end
      total++; if (m_res_v !== 1'b1 || m_res !== 40'd9 || m_ovf !== 1'b0) begin bad++; $display("FAIL mreg_res: got v=%b res=%0d ovf=%b want v=1 res=9 ovf=0", m_res_v, m_res, m_ovf); end
      total++; if (d_down !== 16'd7 || d_down_v !== 1'b0 || d_right_l !== 1'b0) begin bad++; $display("FAIL fwd_hold: got %0d v=%b last=%b want 7 v=0 last=0", d_down, d_down_v, d_right_l); end
      step();
      total++; if (m_res_v !== 1'b0) begin bad++; $display("FAIL mreg_strobe_len: got %b want 0", m_res_v); end
      $display("mul_reg: res=%0d", m_res);
   endtask

   task automatic test_alternate();
      beat(16'd10, 1'b1, 16'd99, 1'b0, 1'b0);
      step();
      total++; if (d_down !== 16'd10 || d_right !== 16'd1 || d_right_v !== 1'b0) begin bad++; $display("FAIL alt_up_only: got %0d/%0d rv=%b want 10/1 rv=0", d_down, d_right, d_right_v); end
      beat(16'd55, 1'b0, 16'd20, 1'b1, 1'b0);
      step();
      total++; if (d_down !== 16'd10 || d_right !== 16'd20 || d_down_v !== 1'b0) begin bad++; $display("FAIL alt_left_only: got %0d/%0d dv=%b want 10/20 dv=0", d_down, d_right, d_down_v); end
      beat(16'd2, 1'b1, 16'd3, 1'b1, 1'b1);
      step();
      total++; if (d_res_v !== 1'b1 || d_res !== 40'd6) begin bad++; $display("FAIL alt_res: got v=%b res=%0d want v=1 res=6", d_res_v, d_res); end
      idle();
      step();
      total++; if (m_res_v !== 1'b1 || m_res !== 40'd6) begin bad++; $display("FAIL alt_mreg_res: got v=%b res=%0d want v=1 res=6", m_res_v, m_res); end
      $display("alternate: res=%0d", d_res);
      step();
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 3; i++) begin
         beat(16'd32767, 1'b1, 16'd32767, 1'b1, (i == 2));
         step();
      end
      total++; if (s_res_v !== 1'b1 || s_res !== 32'h7FFFFFFF || s_ovf !== 1'b1) begin bad++; $display("FAIL sat_res: got v=%b res=%h ovf=%b want v=1 res=7fffffff ovf=1", s_res_v, s_res, s_ovf); end
      total++; if (w_res_v !== 1'b1 || w_res !== 32'hBFFD0003 || w_ovf !== 1'b1) begin bad++; $display("FAIL wrap_res: got v=%b res=%h ovf=%b want v=1 res=bffd0003 ovf=1", w_res_v, w_res, w_ovf); end
      total++; if (d_res !== 40'd3221028867 || d_ovf !== 1'b0) begin bad++; $display("FAIL wide_res: got %0d ovf=%b want 3221028867 ovf=0", d_res, d_ovf); end
      $display("saturate: sat=%h wrap=%h", s_res, w_res);
      idle();
      step(); step();
      total++; if (s_res !== 32'h7FFFFFFF || s_ovf !== 1'b1 || s_res_v !== 1'b0) begin bad++; $display("FAIL sat_hold: got res=%h ovf=%b v=%b want 7fffffff 1 0", s_res, s_ovf, s_res_v); end
   endtask

   task automatic test_back_to_back();
      beat(16'd1, 1'b1, 16'd1, 1'b1, 1'b1);
      step();
      total++; if (d_res_v !== 1'b1 || d_res !== 40'd1 || d_ovf !== 1'b0) begin bad++; $display("FAIL b2b_first: got v=%b res=%0d ovf=%b want 1 1 0", d_res_v, d_res, d_ovf); end
      total++; if (s_res !== 32'd1 || s_ovf !== 1'b0) begin bad++; $display("FAIL b2b_ovf_clear: got res=%0d ovf=%b want 1 0", s_res, s_ovf); end
      beat(16'd2, 1'b1, 16'd2, 1'b1, 1'b1);
      step();
      total++; if (d_res_v !== 1'b1 || d_res !== 40'd4 || d_ovf !== 1'b0) begin bad++; $display("FAIL b2b_second: got v=%b res=%0d ovf=%b want 1 4 0", d_res_v, d_res, d_ovf); end
      total++; if (m_res_v !== 1'b1 || m_res !== 40'd1) begin bad++; $display("FAIL b2b_mreg_first: got v=%b res=%0d want 1 1", m_res_v, m_res); end
      idle();
      step();
      total++; if (m_res_v !== 1'b1 || m_res !== 40'd4) begin bad++; $display("FAIL b2b_mreg_second: got v=%b res=%0d want 1 4", m_res_v, m_res); end
      $display("back_to_back: res=%0d", d_res);
      step();
   endtask

   task automatic test_clear();
      beat(16'd5, 1'b1, 16'd5, 1'b1, 1'b0);
      step();
      beat(16'd1, 1'b1, 16'd1, 1'b1, 1'b1);
      clear = 1'b1;
      step();
      total++; if (d_res_v !== 1'b0 || d_res !== 40'd4) begin bad++; $display("FAIL clear_no_strobe: got v=%b res=%0d want 0 4", d_res_v, d_res); end
      total++; if (d_right_l !== 1'b1 || d_down !== 16'd1) begin bad++; $display("FAIL clear_fwd: got last=%b down=%0d want 1 1", d_right_l, d_down); end
      clear = 1'b0; idle();
      step();
      total++; if (m_res_v !== 1'b0 || m_res !== 40'd4) begin bad++; $display("FAIL clear_mreg: got v=%b res=%0d want 0 4", m_res_v, m_res); end
      beat(16'd1, 1'b1, 16'd1, 1'b1, 1'b1);
      step();
      total++; if (d_res_v !== 1'b1 || d_res !== 40'd1) begin bad++; $display("FAIL clear_next: got v=%b res=%0d want 1 1", d_res_v, d_res); end
      idle();
      step();
      total++; if (m_res_v !== 1'b1 || m_res !== 40'd1) begin bad++; $display("FAIL clear_mreg_next: got v=%b res=%0d want 1 1", m_res_v, m_res); end
      $display("clear: res=%0d", d_res);
      step();
   endtask

   task automatic test_reset_mid();
      // leave a set ovf on the saturating instance so reset has something to clear
      for (int i = 0; i < 3; i++) begin
         beat(16'd32767, 1'b1, 16'd32767, 1'b1, (i == 2));
         step();
      end
      beat(16'd3, 1'b1, 16'd3, 1'b1, 1'b0);
      step();
      rst_n = 1'b0;
      beat(16'd1, 1'b1, 16'd1, 1'b1, 1'b1);
      step();
      total++; if ({d_down, d_right, d_down_v, d_right_v, d_right_l, d_res_v, d_ovf} !== 37'h0 || d_res !== 40'h0) begin bad++; $display("FAIL rst_mid_dut: got down=%h right=%h res=%h flags=%b want all 0", d_down, d_right, d_res, {d_down_v, d_right_v, d_right_l, d_res_v, d_ovf}); end
      total++; if (s_ovf !== 1'b0 || s_res !== 32'h0 || m_res !== 40'h0) begin bad++; $display("FAIL rst_mid_other: got s_ovf=%b s_res=%h m_res=%h want 0", s_ovf, s_res, m_res); end
      rst_n = 1'b1;
      beat(16'd2, 1'b1, 16'd2, 1'b1, 1'b1);
      step();
      total++; if (d_res_v !== 1'b1 || d_res !== 40'd4) begin bad++; $display("FAIL rst_mid_fresh: got v=%b res=%0d want 1 4", d_res_v, d_res); end
      idle();
      step();
      total++; if (m_res_v !== 1'b1 || m_res !== 40'd4) begin bad++; $display("FAIL rst_mid_mreg_fresh: got v=%b res=%0d want 1 4", m_res_v, m_res); end
      $display("reset_mid: res=%0d", d_res);
   endtask

   initial begin
      idle();
      test_reset();
      test_basic();
      test_alternate();
      test_saturate();
      test_back_to_back();
      test_clear();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
